// File: rtl/trace_pkg.sv
// Shared constants and types for the TPIU trace capture front-end.
// SYNC_WORD is the full TPIU sync in arrival order (bytes FF,FF,FF,7F).
package trace_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'h7FFF_FFFF;
    localparam int          FRAME_BYTES = 16;
    localparam int          PIPE_DEPTH  = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } state_t;

endpackage

// File: rtl/tpiu_byte_pipe.sv
// tpiu_byte_pipe: 3-deep byte delay line so sync preamble bytes can be retracted.
// Ports: ext_clock/resetn, i_push/i_byte in, i_flush drops all, o_pop_valid/o_pop_data out.
module tpiu_byte_pipe
    import trace_pkg::*;
(
    input  logic       ext_clock,
    input  logic       resetn,
    input  logic       i_push,
    input  logic       i_flush,
    input  logic [7:0] i_byte,
    output logic       o_pop_valid,
    output logic [7:0] o_pop_data
);

    logic [7:0]            r_byte [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] r_vld;

    // Oldest entry leaves only when a new byte arrives into a full line.
    assign o_pop_valid = i_push && !i_flush && r_vld[PIPE_DEPTH-1];
    assign o_pop_data  = r_byte[PIPE_DEPTH-1];

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            r_vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_byte[i] <= '0;
            end
        end else if (i_flush) begin
            r_vld <= '0;
        end else if (i_push) begin
            r_vld     <= {r_vld[PIPE_DEPTH-2:0], 1'b1};
            r_byte[0] <= i_byte;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_byte[i] <= r_byte[i-1];
            end
        end
    end

endmodule

// File: rtl/tpiu_frame_sync.sv
// tpiu_frame_sync: deserializes the 4-bit TPIU port, locks on full sync, strips sync bytes.
// Ports: ext_clock, resetn, TRCENA, TRACEDATA[3:0], I_clear in; O_data, O_data_valid,
//        O_frame_start, O_synced, O_resync_count out (all registered).
module tpiu_frame_sync
    import trace_pkg::*;
#(
    parameter logic [31:0] pSYNC_WORD   = SYNC_WORD,
    parameter int          pFRAME_BYTES = FRAME_BYTES,
    parameter int          pCNT_WIDTH   = 8
) (
    input  logic                  ext_clock,
    input  logic                  resetn,
    input  logic                  TRCENA,
    input  logic [3:0]            TRACEDATA,
    input  logic                  I_clear,
    output logic [7:0]            O_data,
    output logic                  O_data_valid,
    output logic                  O_frame_start,
    output logic                  O_synced,
    output logic [pCNT_WIDTH-1:0] O_resync_count
);

    localparam int IDX_W = $clog2(pFRAME_BYTES);

    state_t           r_state;
    logic [31:0]      r_sr;
    logic             r_phase;
    logic [IDX_W-1:0] r_idx;

    logic [31:0] w_sr_next;
    logic        w_hit;
    logic        w_byte_done;
    logic        w_push;
    logic        w_flush;
    logic        w_misalign;
    logic        w_pop_valid;
    logic [7:0]  w_pop_data;

    // New nibble enters at the top, so the lo nibble of a byte sits below its hi nibble.
    assign w_sr_next   = {TRACEDATA, r_sr[31:4]};
    assign w_hit       = TRCENA && (w_sr_next == pSYNC_WORD);
    assign w_byte_done = TRCENA && (r_state == SYNCED) && r_phase;
    // The 7F that completes an aligned sync is never pushed.
    assign w_push      = w_byte_done && !w_hit;
    assign w_flush     = !TRCENA || w_hit;
    assign w_misalign  = w_hit && (r_state == SYNCED) && !r_phase;

    tpiu_byte_pipe u_pipe (
        .ext_clock   (ext_clock),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_flush     (w_flush),
        .i_byte      (w_sr_next[31:24]),
        .o_pop_valid (w_pop_valid),
        .o_pop_data  (w_pop_data)
    );

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= HUNT;
            r_sr          <= '0;
            r_phase       <= 1'b0;
            r_idx         <= '0;
            O_data        <= '0;
            O_data_valid  <= 1'b0;
            O_frame_start <= 1'b0;
            O_synced      <= 1'b0;
        end else if (!TRCENA) begin
            r_state       <= HUNT;
            r_sr          <= '0;
            r_phase       <= 1'b0;
            O_data_valid  <= 1'b0;
            O_frame_start <= 1'b0;
            O_synced      <= 1'b0;
        end else begin
            r_sr          <= w_sr_next;
            O_data_valid  <= w_pop_valid;
            O_frame_start <= w_pop_valid && (r_idx == '0);
            if (w_pop_valid) begin
                O_data <= w_pop_data;
                r_idx  <= r_idx + 1'b1;
            end
            unique case (r_state)
                HUNT: begin
                    if (w_hit) begin
                        r_state  <= SYNCED;
                        O_synced <= 1'b1;
                        r_phase  <= 1'b0;
                        r_idx    <= '0;
                    end
                end
                SYNCED: begin
                    // Any hit restarts framing; the next nibble is a lo nibble.
                    if (w_hit) begin
                        r_phase <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_phase <= ~r_phase;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            O_resync_count <= '0;
        end else if (I_clear) begin
            O_resync_count <= '0;
        end else if (w_misalign && (O_resync_count != '1)) begin
            O_resync_count <= O_resync_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_tpiu_frame_sync.sv
// Directed bench for tpiu_frame_sync (default counter and a 2-bit counter copy).
// Both instances share stimulus; emitted bytes are logged at the falling edge.
module tb_tpiu_frame_sync;

    logic       ext_clock = 1'b0;
    logic       resetn    = 1'b0;
    logic       TRCENA    = 1'b0;
    logic [3:0] TRACEDATA = 4'h0;
    logic       I_clear   = 1'b0;

    logic [7:0] O_data;
    logic       O_data_valid;
    logic       O_frame_start;
    logic       O_synced;
    logic [7:0] O_resync_count;

    logic [7:0] s_data;
    logic       s_data_valid;
    logic       s_frame_start;
    logic       s_synced;
    logic [1:0] s_resync_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] q[$];

    always #5 ext_clock = ~ext_clock;

    tpiu_frame_sync dut (
        .ext_clock      (ext_clock),
        .resetn         (resetn),
        .TRCENA         (TRCENA),
        .TRACEDATA      (TRACEDATA),
        .I_clear        (I_clear),
        .O_data         (O_data),
        .O_data_valid   (O_data_valid),
        .O_frame_start  (O_frame_start),
        .O_synced       (O_synced),
        .O_resync_count (O_resync_count)
    );

    tpiu_frame_sync #(.pCNT_WIDTH(2)) dut2 (
        .ext_clock      (ext_clock),
        .resetn         (resetn),
        .TRCENA         (TRCENA),
        .TRACEDATA      (TRACEDATA),
        .I_clear        (I_clear),
        .O_data         (s_data),
        .O_data_valid   (s_data_valid),
        .O_frame_start  (s_frame_start),
        .O_synced       (s_synced),
        .O_resync_count (s_resync_count)
    );

    always @(negedge ext_clock) begin
        if (O_data_valid) q.push_back({O_frame_start, O_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nib(input logic [3:0] n, input logic clr = 1'b0);
        TRACEDATA = n;
        I_clear   = clr;
        @(posedge ext_clock);
        #1;
        I_clear   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[3:0]);
        nib(b[7:4]);
    endtask

    task automatic send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7F);
    endtask

    // One stray nibble, then a full sync: lands off the byte boundary.
    task automatic mis_sync(input logic clr);
        nib(4'h5);
        for (int i = 0; i < 7; i++) nib(4'hF);
        nib(4'h7, clr);
    endtask

    task automatic settle();
        @(negedge ext_clock);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge ext_clock);
        #1;
        chk("rst_valid", O_data_valid, 0);
        chk("rst_synced", O_synced, 0);
        chk("rst_data", O_data, 0);
        chk("rst_fs", O_frame_start, 0);
        chk("rst_cnt", O_resync_count, 0);
        resetn = 1'b1;
        TRCENA = 1'b1;

        // Lock on sync, then 00..0F
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        nib(4'hF);
        chk("pre_sync_synced", O_synced, 0);
        nib(4'h7);
        chk("lock_synced", O_synced, 1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        settle();
        chk("b_qsize", q.size(), 13);
        for (int i = 0; i < 13; i++)
            chk("b_byte", {23'd0, q[i]}, {23'd0, i == 0, 8'(i)});
        chk("b_hold_data", O_data, 8'h0C);

        // Aligned sync mid-frame
        q.delete();
        send_sync();
        for (int i = 16; i < 20; i++) send_byte(8'(i));
        settle();
        chk("c_qsize", q.size(), 4);
        chk("c_b0", {23'd0, q[0]}, 32'h00D);
        chk("c_b1", {23'd0, q[1]}, 32'h00E);
        chk("c_b2", {23'd0, q[2]}, 32'h00F);
        chk("c_b3", {23'd0, q[3]}, 32'h110);
        chk("c_cnt", O_resync_count, 0);

        // Sync shifted by one nibble
        q.delete();
        mis_sync(1'b0);
        chk("d_cnt", O_resync_count, 1);
        chk("d_cnt2", s_resync_count, 1);
        send_byte(8'hA5);
        send_byte(8'hB6);
        send_byte(8'hC7);
        send_byte(8'hD8);
        settle();
        chk("d_qsize", q.size(), 5);
        chk("d_b0", {23'd0, q[0]}, 32'h011);
        chk("d_b1", {23'd0, q[1]}, 32'h012);
        chk("d_b2", {23'd0, q[2]}, 32'h013);
        chk("d_b3", {23'd0, q[3]}, 32'h0F5);
        chk("d_b4", {23'd0, q[4]}, 32'h1A5);
        chk("d_synced", O_synced, 1);

        // TRCENA low for one cycle
        q.delete();
        TRCENA = 1'b0;
        @(posedge ext_clock);
        #1;
        TRCENA = 1'b1;
        chk("e_synced", O_synced, 0);
        chk("e_valid", O_data_valid, 0);
        chk("e_hold_data", O_data, 8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        settle();
        chk("e_qsize", q.size(), 0);
        chk("e_synced2", O_synced, 0);

        // Garbage nibble, then sync from HUNT
        q.delete();
        nib(4'h5);
        send_sync();
        chk("f_synced", O_synced, 1);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        settle();
        chk("f_qsize", q.size(), 1);
        chk("f_b0", {23'd0, q[0]}, 32'h1A5);
        chk("f_cnt", O_resync_count, 1);

        // Counter saturation, then clear colliding with an increment
        mis_sync(1'b0);
        mis_sync(1'b0);
        chk("g_cnt3", O_resync_count, 3);
        chk("g_cnt3_s", s_resync_count, 3);
        mis_sync(1'b0);
        mis_sync(1'b0);
        chk("g_cnt5", O_resync_count, 5);
        chk("g_sat_s", s_resync_count, 3);
        mis_sync(1'b1);
        chk("g_clr", O_resync_count, 0);
        chk("g_clr_s", s_resync_count, 0);

        // Async reset mid-stream
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        chk("h_pre_valid", O_data_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("h_valid", O_data_valid, 0);
        chk("h_synced", O_synced, 0);
        chk("h_data", O_data, 0);
        chk("h_cnt", O_resync_count, 0);
        @(posedge ext_clock);
        #1;
        resetn = 1'b1;
        q.delete();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        settle();
        chk("h_nosync_q", q.size(), 0);
        chk("h_nosync", O_synced, 0);
        send_sync();
        chk("h_relock", O_synced, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
